// File: rtl/fu_dispatch_queue.sv
// In-order dispatch queue between decode and the functional units.
// Circular FIFO of decoded instructions; the head entry is offered to exactly one FU.
module fu_dispatch_queue #(
   parameter int DEPTH        = 4,
   parameter int MAX_OPERANDS = 3,
   parameter int TAG_W        = 4
) (
   input  logic                            clk,
   input  logic                            rst,
   input  logic                            flush,
   input  logic                            in_valid,
   output logic                            in_ready,
   input  logic [31:0]                     in_instr,
   input  logic [1:0]                      in_fu_choice,
   input  logic [6*MAX_OPERANDS-1:0]       in_arn_inputs,
   input  logic [6*MAX_OPERANDS-1:0]       in_arn_outputs,
   output logic [3:0]                      fu_valid,
   input  logic [3:0]                      fu_ready,
   output logic [31:0]                     out_instr,
   output logic [6*MAX_OPERANDS-1:0]       out_arn_inputs,
   output logic [6*MAX_OPERANDS-1:0]       out_arn_outputs,
   output logic [TAG_W-1:0]                out_tag,
   output logic [$clog2(DEPTH+1)-1:0]      occupancy,
   output logic [15:0]                     stall_cycles
);

   localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CNT_W = $clog2(DEPTH + 1);
   localparam int ARN_W = 6 * MAX_OPERANDS;

   logic [31:0]       instr_mem_r [DEPTH];
   logic [ARN_W-1:0]  arn_in_mem_r [DEPTH];
   logic [ARN_W-1:0]  arn_out_mem_r [DEPTH];
   logic [1:0]        fu_mem_r [DEPTH];
   logic [TAG_W-1:0]  tag_mem_r [DEPTH];

   logic [PTR_W-1:0]  head_r;
   logic [PTR_W-1:0]  tail_r;
   logic [CNT_W-1:0]  count_r;
   logic [TAG_W-1:0]  tag_ctr_r;
   logic [15:0]       stall_r;

   logic              has_entry_s;
   logic              enq_s;
   logic              deq_s;

   function automatic logic [PTR_W-1:0] next_ptr(input logic [PTR_W-1:0] ptr);
      if (ptr == PTR_W'(DEPTH - 1)) begin
         next_ptr = PTR_W'(0);
      end else begin
         next_ptr = ptr + PTR_W'(1);
      end
   endfunction

   assign has_entry_s = (count_r != CNT_W'(0));
   assign in_ready    = (count_r < CNT_W'(DEPTH));
   assign occupancy   = count_r;
   assign stall_cycles = stall_r;

   // Flush and reset suppress both queue movements for the cycle.
   assign enq_s = in_valid && in_ready && !flush && !rst;
   assign deq_s = (|(fu_valid & fu_ready)) && !flush && !rst;

   // Head entry presentation: zeros whenever the queue is empty.
   always_comb begin
      fu_valid        = 4'b0000;
      out_instr       = 32'h0000_0000;
      out_arn_inputs  = {ARN_W{1'b0}};
      out_arn_outputs = {ARN_W{1'b0}};
      out_tag         = {TAG_W{1'b0}};
      if (has_entry_s) begin
         out_instr       = instr_mem_r[head_r];
         out_arn_inputs  = arn_in_mem_r[head_r];
         out_arn_outputs = arn_out_mem_r[head_r];
         out_tag         = tag_mem_r[head_r];
         case (fu_mem_r[head_r])
            2'd0:    fu_valid = 4'b0001;
            2'd1:    fu_valid = 4'b0010;
            2'd2:    fu_valid = 4'b0100;
            2'd3:    fu_valid = 4'b1000;
            default: fu_valid = 4'b0000;
         endcase
      end else begin
         fu_valid = 4'b0000;
      end
   end

   // Entry storage; validity is tracked solely by head/count.
   always_ff @(posedge clk) begin
      if (enq_s) begin
         instr_mem_r[tail_r]   <= in_instr;
         arn_in_mem_r[tail_r]  <= in_arn_inputs;
         arn_out_mem_r[tail_r] <= in_arn_outputs;
         fu_mem_r[tail_r]      <= in_fu_choice;
         tag_mem_r[tail_r]     <= tag_ctr_r;
      end
   end

   // Pointers, count and tag counter.
   always_ff @(posedge clk) begin
      if (rst) begin
         head_r    <= PTR_W'(0);
         tail_r    <= PTR_W'(0);
         count_r   <= CNT_W'(0);
         tag_ctr_r <= TAG_W'(0);
      end else if (flush) begin
         head_r    <= PTR_W'(0);
         tail_r    <= PTR_W'(0);
         count_r   <= CNT_W'(0);
      end else begin
         if (enq_s) begin
            tail_r    <= next_ptr(tail_r);
            tag_ctr_r <= tag_ctr_r + TAG_W'(1);
         end
         if (deq_s) begin
            head_r <= next_ptr(head_r);
         end
         case ({enq_s, deq_s})
            2'b10:   count_r <= count_r + CNT_W'(1);
            2'b01:   count_r <= count_r - CNT_W'(1);
            default: count_r <= count_r;
         endcase
      end
   end

   // Saturating count of cycles where a valid head was not taken.
   always_ff @(posedge clk) begin
      if (rst) begin
         stall_r <= 16'h0000;
      end else if (!flush && has_entry_s && !deq_s && (stall_r != 16'hFFFF)) begin
         stall_r <= stall_r + 16'h0001;
      end else begin
         stall_r <= stall_r;
      end
   end

endmodule

// File: tb/tb_fu_dispatch_queue.sv
// Directed self-checking bench for fu_dispatch_queue (DEPTH=4, MAX_OPERANDS=3, TAG_W=4).
module tb_fu_dispatch_queue;

   logic        clk = 1'b0;
   logic        rst, flush, in_valid, in_ready;
   logic [31:0] in_instr;
   logic [1:0]  in_fu_choice;
   logic [17:0] in_arn_inputs, in_arn_outputs;
   logic [3:0]  fu_valid, fu_ready;
   logic [31:0] out_instr;
   logic [17:0] out_arn_inputs, out_arn_outputs;
   logic [3:0]  out_tag;
   logic [2:0]  occupancy;
   logic [15:0] stall_cycles;

   int n_checks = 0;
   int n_errors = 0;

   fu_dispatch_queue #(.DEPTH(4), .MAX_OPERANDS(3), .TAG_W(4)) dut (
      .clk(clk), .rst(rst), .flush(flush),
      .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr),
      .in_fu_choice(in_fu_choice), .in_arn_inputs(in_arn_inputs),
      .in_arn_outputs(in_arn_outputs), .fu_valid(fu_valid), .fu_ready(fu_ready),
      .out_instr(out_instr), .out_arn_inputs(out_arn_inputs),
      .out_arn_outputs(out_arn_outputs), .out_tag(out_tag),
      .occupancy(occupancy), .stall_cycles(stall_cycles)
   );

   always #5 clk = ~clk;

   function automatic logic [17:0] arn_in_f(input logic [31:0] i);
      return 18'(i * 32'd3);
   endfunction

   function automatic logic [17:0] arn_out_f(input logic [31:0] i);
      return 18'(i * 32'd5);
   endfunction

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      n_checks++;
      assert (obs === exp) else begin
         n_errors++;
         $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
      end
   endtask

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic drive(input logic v, input logic [31:0] instr, input logic [1:0] fu);
      in_valid       = v;
      in_instr       = instr;
      in_fu_choice   = fu;
      in_arn_inputs  = arn_in_f(instr);
      in_arn_outputs = arn_out_f(instr);
   endtask

   task automatic chk_reset_state(input string tag);
      chk({tag, "_occ"},   32'(occupancy), 32'd0);
      chk({tag, "_rdy"},   32'(in_ready), 32'd1);
      chk({tag, "_fuv"},   32'(fu_valid), 32'd0);
      chk({tag, "_instr"}, out_instr, 32'd0);
      chk({tag, "_ain"},   32'(out_arn_inputs), 32'd0);
      chk({tag, "_aout"},  32'(out_arn_outputs), 32'd0);
      chk({tag, "_tag"},   32'(out_tag), 32'd0);
      chk({tag, "_stall"}, 32'(stall_cycles), 32'd0);
   endtask

   initial begin
      rst = 1'b1; flush = 1'b0; fu_ready = 4'b0000;
      drive(1'b0, 32'd0, 2'd0);
      tick(); tick();
      rst = 1'b0;
      chk_reset_state("reset");

      // Single ADD to the ALU, taken the cycle after it appears.
      drive(1'b1, 32'h00A0_0033, 2'd2);
      fu_ready = 4'b0100;
      tick();
      drive(1'b0, 32'd0, 2'd0);
      chk("add_occ",   32'(occupancy), 32'd1);
      chk("add_fuv",   32'(fu_valid), 32'h4);
      chk("add_tag",   32'(out_tag), 32'd0);
      chk("add_instr", out_instr, 32'h00A0_0033);
      chk("add_ain",   32'(out_arn_inputs), 32'(arn_in_f(32'h00A0_0033)));
      chk("add_aout",  32'(out_arn_outputs), 32'(arn_out_f(32'h00A0_0033)));
      tick();
      chk("add_pop_occ", 32'(occupancy), 32'd0);
      chk("add_pop_fuv", 32'(fu_valid), 32'd0);
      chk("add_stall",   32'(stall_cycles), 32'd0);

      // Fill to DEPTH with nothing ready; a fifth request must be dropped.
      rst = 1'b1; tick(); rst = 1'b0;
      fu_ready = 4'b0000;
      for (int i = 0; i < 4; i++) begin
         drive(1'b1, 32'd100 + 32'(i), 2'd3);
         tick();
      end
      drive(1'b1, 32'd999, 2'd3);
      tick();
      drive(1'b0, 32'd0, 2'd0);
      chk("full_occ",   32'(occupancy), 32'd4);
      chk("full_rdy",   32'(in_ready), 32'd0);
      chk("full_stall", 32'(stall_cycles), 32'd4);
      fu_ready = 4'b1000;
      for (int i = 0; i < 4; i++) begin
         chk("full_tag",   32'(out_tag), 32'(i));
         chk("full_instr", out_instr, 32'd100 + 32'(i));
         chk("full_fuv",   32'(fu_valid), 32'h8);
         tick();
      end
      chk("full_drain_occ",   32'(occupancy), 32'd0);
      chk("full_drain_stall", 32'(stall_cycles), 32'd4);

      // LSU head blocks a younger logical-FU entry whose unit is ready.
      rst = 1'b1; tick(); rst = 1'b0;
      fu_ready = 4'b0001;
      drive(1'b1, 32'd200, 2'd1); tick();
      drive(1'b1, 32'd201, 2'd0); tick();
      drive(1'b0, 32'd0, 2'd0);
      repeat (5) tick();
      chk("blk_occ",   32'(occupancy), 32'd2);
      chk("blk_fuv",   32'(fu_valid), 32'h2);
      chk("blk_instr", out_instr, 32'd200);
      chk("blk_tag",   32'(out_tag), 32'd0);
      // One blocked cycle while the second entry was written, then five more.
      chk("blk_stall", 32'(stall_cycles), 32'd6);
      fu_ready = 4'b0010;
      tick();
      chk("blk_next_occ",   32'(occupancy), 32'd1);
      chk("blk_next_instr", out_instr, 32'd201);
      chk("blk_next_fuv",   32'(fu_valid), 32'h1);
      chk("blk_next_tag",   32'(out_tag), 32'd1);
      fu_ready = 4'b0001;
      tick();
      chk("blk_done_occ",   32'(occupancy), 32'd0);
      chk("blk_done_stall", 32'(stall_cycles), 32'd6);

      // Steady state at count 2 with enqueue and dispatch together.
      fu_ready = 4'b0000;
      drive(1'b1, 32'd300, 2'd2); tick();
      drive(1'b1, 32'd301, 2'd2); tick();
      chk("ss_fill_occ", 32'(occupancy), 32'd2);
      fu_ready = 4'b0100;
      for (int k = 0; k < 3; k++) begin
         drive(1'b1, 32'd302 + 32'(k), 2'd2);
         tick();
         chk("ss_occ",   32'(occupancy), 32'd2);
         chk("ss_instr", out_instr, 32'd301 + 32'(k));
         chk("ss_tag",   32'(out_tag), 32'd3 + 32'(k));
      end
      drive(1'b0, 32'd0, 2'd0);
      tick();
      chk("ss_tail_instr", out_instr, 32'd304);
      chk("ss_tail_tag",   32'(out_tag), 32'd6);
      tick();
      chk("ss_empty_occ", 32'(occupancy), 32'd0);
      chk("ss_stall",     32'(stall_cycles), 32'd7);

      // Seventeen pass-through entries: tag wraps from 15 to 0.
      rst = 1'b1; tick(); rst = 1'b0;
      fu_ready = 4'b0100;
      for (int i = 0; i < 17; i++) begin
         drive(1'b1, 32'd400 + 32'(i), 2'd2);
         tick();
         chk("wrap_tag", 32'(out_tag), 32'(i % 16));
         chk("wrap_occ", 32'(occupancy), 32'd1);
      end
      fu_ready = 4'b0000;
      drive(1'b1, 32'd500, 2'd2); tick();
      drive(1'b1, 32'd501, 2'd2); tick();
      chk("fl_pre_occ", 32'(occupancy), 32'd3);
      flush = 1'b1;
      drive(1'b1, 32'd502, 2'd2);
      tick();
      flush = 1'b0;
      chk("fl_occ",   32'(occupancy), 32'd0);
      chk("fl_fuv",   32'(fu_valid), 32'd0);
      chk("fl_instr", out_instr, 32'd0);
      chk("fl_rdy",   32'(in_ready), 32'd1);
      drive(1'b1, 32'd503, 2'd2);
      tick();
      drive(1'b0, 32'd0, 2'd0);
      chk("fl_next_tag",   32'(out_tag), 32'd3);
      chk("fl_next_instr", out_instr, 32'd503);
      chk("fl_next_occ",   32'(occupancy), 32'd1);
      chk("fl_stall",      32'(stall_cycles), 32'd2);

      // Long block saturates the stall counter; head stays put.
      repeat (65540) @(posedge clk);
      #1;
      chk("sat_stall", 32'(stall_cycles), 32'hFFFF);
      chk("sat_fuv",   32'(fu_valid), 32'h4);
      chk("sat_instr", out_instr, 32'd503);

      // Reset wins over flush and enqueue with entries queued.
      drive(1'b1, 32'd504, 2'd1); tick();
      drive(1'b1, 32'd505, 2'd1); tick();
      chk("rst_pre_occ", 32'(occupancy), 32'd3);
      rst = 1'b1; flush = 1'b1;
      drive(1'b1, 32'd506, 2'd1);
      tick();
      rst = 1'b0; flush = 1'b0;
      drive(1'b0, 32'd0, 2'd0);
      chk_reset_state("rst_mid");
      drive(1'b1, 32'd600, 2'd1);
      tick();
      drive(1'b0, 32'd0, 2'd0);
      chk("rst_new_tag", 32'(out_tag), 32'd0);
      chk("rst_new_fuv", 32'(fu_valid), 32'h2);

      $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
      $finish;
   end

endmodule
